serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Bit-serial pattern transmitter. It is the source end of the single-bit serial stream that the team's sequence detectors consume.
- It latches a PATTERN_W-bit word and shifts it out MSB-first, one bit per clk.
- It can repeat the frame a programmable number of times, with an idle gap between frames.
- It reports busy/done status so a controller or testbench can chain transfers.

Parameters:
- PATTERN_W, 5, width of the pattern frame in bits (legal 2..16)
- GAP_LEVEL, 1'b0, value driven on x_out while idle or in an inter-frame gap
- DEFAULT_PATTERN, 5'b10101, value loaded into the pattern register at reset

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- abort  in  1  synchronous cancel of the transfer in progress
- pattern  in  PATTERN_W  frame to send; captured on accepted start
- repeat_cnt  in  8  number of frames to send; 0 is treated as 1
- gap_len  in  4  idle cycles inserted between frames (not after the last frame)
- x_out  out  1  serial data, registered
- bit_valid  out  1  high while x_out carries a pattern bit
- busy  out  1  high from accepted start until the transfer ends
- done  out  1  one-cycle pulse after the last bit of the last frame
- bit_idx  out  4  index of the bit currently on x_out; 0 = MSB
- frames_sent  out  8  frames completed in the current or most recent run

Behaviour:
- Reset (rst=1 at posedge), regardless of state:
  - state=IDLE
  - x_out=GAP_LEVEL, bit_valid=0, busy=0, done=0, bit_idx=0, frames_sent=0
  - pattern register=DEFAULT_PATTERN
  - rst has priority over start and abort.
- All outputs are registered.
- States: IDLE, SEND, GAP, FINISH.
- IDLE:
  - x_out=GAP_LEVEL, bit_valid=0.
  - start=1 at edge E0 performs all of the following at that edge:
    - latch pattern; latch max(repeat_cnt,1) as N; latch gap_len as G
    - clear frames_sent; set busy=1; go to SEND
    - drive x_out=pattern[PATTERN_W-1], bit_valid=1, bit_idx=0
  - Latency is one clock from start to the first bit.
- SEND:
  - Each edge advances bit_idx by 1 and drives the next lower pattern bit.
  - Bit k is on x_out in the cycle following edge E0+k.
  - At the edge leaving the last bit (bit_idx=PATTERN_W-1):
    - frames_sent increments.
    - If frames_sent+1 < N and G>0: go to GAP with bit_valid=0, x_out=GAP_LEVEL.
    - If frames_sent+1 < N and G=0: wrap back-to-back with bit_idx=0 and the MSB on x_out in the next cycle (no bubble).
    - If frames_sent+1 = N: go to FINISH.
- GAP:
  - Holds x_out=GAP_LEVEL and bit_valid=0 for exactly G cycles.
  - Then re-enters SEND with bit_idx=0 and the MSB on x_out.
- FINISH:
  - Lasts one cycle: done=1, busy=0, bit_valid=0, x_out=GAP_LEVEL.
  - Next edge: done=0, go to IDLE.
  - done first appears after edge E0 + N*PATTERN_W + (N-1)*G.
  - start seen during FINISH is ignored; start is accepted from IDLE only.
- start while busy=1 is ignored. It is not queued and does not alter the latched values.
- Changes on pattern, repeat_cnt or gap_len while busy have no effect on the current run.
- abort=1 in SEND or GAP:
  - Next state is IDLE; busy=0, bit_valid=0, x_out=GAP_LEVEL. done is not pulsed.
  - frames_sent holds the count of frames completed before the abort.
  - abort in IDLE or FINISH has no effect; FINISH still pulses done.
- abort and start in the same cycle in IDLE: start wins, because abort is ignored in IDLE.
- frames_sent saturates at 255; this cannot overflow, since N<=255.
- bit_idx is 0 whenever bit_valid=0.

Test Plan:
1. Basic frame: reset, then start=1 for one cycle with pattern=5'b10101, repeat_cnt=1, gap_len=0.
   - x_out=1,0,1,0,1 with bit_valid=1 in the 5 cycles after the start edge.
   - done pulses in the 6th cycle; busy is high for exactly 5 cycles; frames_sent=1.
2. Repeat with gap: pattern=5'b11001, repeat_cnt=2, gap_len=3.
   - x_out = 1,1,0,0,1, then three GAP_LEVEL cycles with bit_valid=0, then 1,1,0,0,1.
   - done appears 13 cycles after the start edge; frames_sent=2.
3. Back-to-back: pattern=5'b10101, repeat_cnt=3, gap_len=0.
   - 15 consecutive valid bits, 101011010110101, with no bubble.
   - repeat_cnt=0 with the same pattern sends exactly 1 frame.
4. Ignored inputs: start pulse at the 2nd bit of a run, and pattern changed to 5'b00000 mid-frame.
   - The original frame completes unchanged, done pulses once, and no second run starts.
5. Abort: repeat_cnt=3, gap_len=2, abort=1 during the 2nd frame's 3rd bit.
   - Next cycle busy=0, bit_valid=0, x_out=GAP_LEVEL; done never pulses; frames_sent=1.
6. Reset mid-run: assert rst during GAP of a 2-frame run.
   - All outputs return to reset values next cycle.
   - A subsequent start with no pattern change sends DEFAULT_PATTERN only if pattern input=5'b10101; otherwise it sends the new input.
   - Verify the first bit appears one cycle after the start edge.

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Handshake and status bundle for the serial pattern transmitter.
interface serial_pattern_tx_if #(
    parameter int unsigned PATTERN_W = 5
);
    logic                 start;
    logic                 abort;
    logic [PATTERN_W-1:0] pattern;
    logic [7:0]           repeat_cnt;
    logic [3:0]           gap_len;
    logic                 x_out;
    logic                 bit_valid;
    logic                 busy;
    logic                 done;
    logic [3:0]           bit_idx;
    logic [7:0]           frames_sent;

    // Controller side: requests transfers and watches status.
    modport master (
        output start, abort, pattern, repeat_cnt, gap_len,
        input  x_out, bit_valid, busy, done, bit_idx, frames_sent
    );

    // Transmitter side.
    modport slave (
        input  start, abort, pattern, repeat_cnt, gap_len,
        output x_out, bit_valid, busy, done, bit_idx, frames_sent
    );
endinterface

// File: rtl/serial_pattern_tx.sv
// Bit-serial pattern transmitter: sends a latched word MSB-first, optionally
// repeating it with an idle gap between frames, and reports busy/done status.
module serial_pattern_tx #(
    parameter int unsigned          PATTERN_W       = 5,
    parameter logic                 GAP_LEVEL       = 1'b0,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(5'b10101)
) (
    input  logic                clk,
    input  logic                rst,
    serial_pattern_tx_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(PATTERN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t               state;
    logic [PATTERN_W-1:0] pat_q;
    logic [PATTERN_W-1:0] sh_q;
    logic [7:0]           n_q;
    logic [3:0]           g_q;
    logic [3:0]           gap_cnt;

    logic                 x_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic [3:0]           idx_q;
    logic [7:0]           fs_q;

    logic [7:0]           fs_inc;

    // Frame count after the frame now ending; held at 255 rather than wrapping.
    assign fs_inc = (fs_q == 8'hFF) ? 8'hFF : fs_q + 8'd1;

    // Transfer FSM with registered outputs; sh_q holds the bits still to send.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= DEFAULT_PATTERN;
            sh_q    <= '0;
            n_q     <= 8'd1;
            g_q     <= 4'd0;
            gap_cnt <= 4'd0;
            x_q     <= GAP_LEVEL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            fs_q    <= 8'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    x_q     <= GAP_LEVEL;
                    valid_q <= 1'b0;
                    idx_q   <= 4'd0;
                    if (bus.start) begin
                        pat_q   <= bus.pattern;
                        sh_q    <= bus.pattern << 1;
                        n_q     <= (bus.repeat_cnt == 8'd0) ? 8'd1 : bus.repeat_cnt;
                        g_q     <= bus.gap_len;
                        fs_q    <= 8'd0;
                        busy_q  <= 1'b1;
                        x_q     <= bus.pattern[PATTERN_W-1];
                        valid_q <= 1'b1;
                        state   <= SEND;
                    end
                end

                SEND: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        x_q     <= GAP_LEVEL;
                        idx_q   <= 4'd0;
                    end else if (idx_q == LAST_IDX) begin
                        fs_q  <= fs_inc;
                        idx_q <= 4'd0;
                        if (fs_inc < n_q) begin
                            if (g_q != 4'd0) begin
                                state   <= GAP;
                                gap_cnt <= g_q;
                                valid_q <= 1'b0;
                                x_q     <= GAP_LEVEL;
                            end else begin
                                // Back-to-back frame: MSB follows LSB with no bubble.
                                x_q  <= pat_q[PATTERN_W-1];
                                sh_q <= pat_q << 1;
                            end
                        end else begin
                            state   <= FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            x_q     <= GAP_LEVEL;
                        end
                    end else begin
                        x_q   <= sh_q[PATTERN_W-1];
                        sh_q  <= sh_q << 1;
                        idx_q <= idx_q + 4'd1;
                    end
                end

                GAP: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        x_q     <= GAP_LEVEL;
                        idx_q   <= 4'd0;
                    end else if (gap_cnt == 4'd1) begin
                        state   <= SEND;
                        x_q     <= pat_q[PATTERN_W-1];
                        sh_q    <= pat_q << 1;
                        valid_q <= 1'b1;
                        idx_q   <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Drive the registered state onto the interface.
    assign bus.x_out       = x_q;
    assign bus.bit_valid   = valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.bit_idx     = idx_q;
    assign bus.frames_sent = fs_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx: builds the expected per-cycle output
// stream of each transfer from frame/gap arithmetic and compares every cycle.
module tb_serial_pattern_tx;

    localparam int unsigned W   = 5;
    localparam logic        GAP = 1'b0;

    typedef struct packed {
        logic       x;
        logic       v;
        logic       busy;
        logic       done;
        logic [3:0] idx;
        logic [7:0] fs;
    } obs_t;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    serial_pattern_tx_if #(.PATTERN_W(W)) bus ();

    serial_pattern_tx #(
        .PATTERN_W       (W),
        .GAP_LEVEL       (GAP),
        .DEFAULT_PATTERN (5'b10101)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observe();
        obs_t o;
        o.x    = bus.x_out;
        o.v    = bus.bit_valid;
        o.busy = bus.busy;
        o.done = bus.done;
        o.idx  = bus.bit_idx;
        o.fs   = bus.frames_sent;
        return o;
    endfunction

    function automatic obs_t idle_obs(input logic [7:0] fs);
        obs_t o;
        o.x = GAP; o.v = 1'b0; o.busy = 1'b0; o.done = 1'b0; o.idx = 4'd0; o.fs = fs;
        return o;
    endfunction

    task automatic check(input string tag, input int cyc, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s cyc%0d: got x=%b v=%b busy=%b done=%b idx=%0d fs=%0d, want x=%b v=%b busy=%b done=%b idx=%0d fs=%0d",
                    tag, cyc, got.x, got.v, got.busy, got.done, got.idx, got.fs,
                    exp.x, exp.v, exp.busy, exp.done, exp.idx, exp.fs);
    endtask

    // One transfer. kill_at>0 asserts abort (or rst) during that cycle after
    // the start edge; glitch pulses start and scrambles the inputs while busy.
    task automatic run(input string tag, input logic [4:0] pat, input int rc, input int gl,
                       input int kill_at, input bit kill_rst, input bit glitch,
                       input bit abort_with_start);
        obs_t q[$];
        obs_t e;
        int   n;
        bit   kill_live;
        logic [7:0] fsk;

        n = (rc == 0) ? 1 : rc;
        for (int f = 0; f < n; f++) begin
            for (int k = 0; k < int'(W); k++) begin
                e.x = pat[4-k]; e.v = 1'b1; e.busy = 1'b1; e.done = 1'b0;
                e.idx = 4'(k); e.fs = 8'(f);
                q.push_back(e);
            end
            if (f < n - 1) begin
                for (int g = 0; g < gl; g++) begin
                    e.x = GAP; e.v = 1'b0; e.busy = 1'b1; e.done = 1'b0;
                    e.idx = 4'd0; e.fs = 8'(f + 1);
                    q.push_back(e);
                end
            end
        end
        e = idle_obs(8'(n));
        e.done = 1'b1;
        q.push_back(e);
        q.push_back(idle_obs(8'(n)));

        kill_live = (kill_at > 0) && (kill_at <= q.size()) &&
                    (kill_rst || q[kill_at-1].busy);
        if (kill_live) begin
            fsk = kill_rst ? 8'd0 : q[kill_at-1].fs;
            while (q.size() > kill_at) void'(q.pop_back());
            q.push_back(idle_obs(fsk));
        end

        bus.pattern    = pat;
        bus.repeat_cnt = 8'(rc);
        bus.gap_len    = 4'(gl);
        bus.start      = 1'b1;
        bus.abort      = abort_with_start;
        @(posedge clk);
        for (int c = 1; c <= q.size(); c++) begin
            @(negedge clk);
            check(tag, c, observe(), q[c-1]);
            bus.start = glitch && (c < q.size()) && (c == 1 || $urandom_range(3) == 0);
            bus.abort = kill_live && !kill_rst && (c == kill_at);
            rst       = kill_live && kill_rst && (c == kill_at);
            if (glitch) begin
                bus.pattern    = (c == 1) ? 5'b00000 : 5'($urandom);
                bus.repeat_cnt = 8'($urandom);
                bus.gap_len    = 4'($urandom);
            end
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        rst       = 1'b0;
    endtask

    // Directed steps followed by randomized transfers.
    initial begin
        int rc;
        int gl;
        int len;
        int kill;
        bit krst;

        total  = 0;
        passed = 0;
        rst    = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.pattern    = 5'b00000;
        bus.repeat_cnt = 8'd0;
        bus.gap_len    = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset", 0, observe(), idle_obs(8'd0));

        run("basic",       5'b10101, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run("gap",         5'b11001, 2, 3, 0, 1'b0, 1'b0, 1'b0);
        run("b2b",         5'b10101, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        run("rc0",         5'b10101, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run("ignored",     5'b10110, 1, 0, 0, 1'b0, 1'b1, 1'b0);
        run("abort",       5'b10101, 3, 2, 10, 1'b0, 1'b0, 1'b0);
        run("abort_fin",   5'b10101, 1, 0, 6, 1'b0, 1'b0, 1'b0);
        run("abort_start", 5'b11001, 1, 0, 0, 1'b0, 1'b0, 1'b1);
        run("rst_gap",     5'b11001, 2, 3, 7, 1'b1, 1'b0, 1'b0);
        run("after_rst",   5'b10101, 1, 0, 0, 1'b0, 1'b0, 1'b0);
        run("new_pat",     5'b01110, 1, 1, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            rc   = int'($urandom_range(4));
            gl   = int'($urandom_range(3));
            len  = ((rc == 0) ? 1 : rc) * int'(W) + (((rc == 0) ? 1 : rc) - 1) * gl + 2;
            kill = ($urandom_range(2) == 0) ? int'($urandom_range(len - 1, 1)) : 0;
            krst = ($urandom_range(3) == 0);
            run("random", 5'($urandom), rc, gl, kill, krst, 1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
